// File: rtl/branch_redirect_arbiter.sv
// rtl/branch_redirect_arbiter.sv - oldest-first mispredict redirect arbiter with flush tracking
module branch_redirect_arbiter #(
  parameter int NUM_BRANCHES = 4,
  parameter int SQN_W        = 7,
  parameter int PC_W         = 32,
  parameter int META_W       = 28,
  localparam int CHAN_W      = (NUM_BRANCHES > 1) ? $clog2(NUM_BRANCHES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_BRANCHES-1:0]          IN_valid,
  input  logic [NUM_BRANCHES*SQN_W-1:0]    IN_sqN,
  input  logic [NUM_BRANCHES*PC_W-1:0]     IN_pc,
  input  logic [NUM_BRANCHES*META_W-1:0]   IN_meta,
  input  logic [SQN_W-1:0]                 IN_ROB_curSqN,
  input  logic                             IN_flushDone,
  output logic                             OUT_valid,
  output logic [SQN_W-1:0]                 OUT_sqN,
  output logic [PC_W-1:0]                  OUT_pc,
  output logic [META_W-1:0]                OUT_meta,
  output logic [CHAN_W-1:0]                OUT_chan,
  output logic                             OUT_flushing,
  output logic [15:0]                      OUT_dropCnt
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_valid;
  logic [SQN_W-1:0]    r_sqN;
  logic [PC_W-1:0]     r_pc;
  logic [META_W-1:0]   r_meta;
  logic [CHAN_W-1:0]   r_chan;
  logic [SQN_W-1:0]    r_pend_sqN;
  logic [15:0]         r_drop_cnt;

  logic                    w_eff_idle;
  logic [SQN_W-1:0]        w_pend_age;
  logic [SQN_W-1:0]        w_age [NUM_BRANCHES];
  logic [NUM_BRANCHES-1:0] w_elig;
  logic                    w_any;
  logic [CHAN_W-1:0]       w_win;
  logic [SQN_W-1:0]        w_win_age;
  logic [SQN_W-1:0]        w_sel_sqN;
  logic [PC_W-1:0]         w_sel_pc;
  logic [META_W-1:0]       w_sel_meta;
  logic [15:0]             w_valid_cnt;
  logic [15:0]             w_drops;
  logic [16:0]             w_cnt_sum;

  // A flushDone arriving this cycle retires the pending flush before eligibility is judged.
  assign w_eff_idle = (r_state == S_IDLE) || IN_flushDone;
  assign w_pend_age = r_pend_sqN - IN_ROB_curSqN;

  for (genvar g = 0; g < NUM_BRANCHES; g++) begin : g_age
    assign w_age[g]  = IN_sqN[g*SQN_W +: SQN_W] - IN_ROB_curSqN;
    assign w_elig[g] = IN_valid[g] && (w_eff_idle || (w_age[g] < w_pend_age));
  end

  // Strict less-than keeps the lowest index on equal age.
  always_comb begin
    w_any       = 1'b0;
    w_win       = '0;
    w_win_age   = '1;
    w_sel_sqN   = '0;
    w_sel_pc    = '0;
    w_sel_meta  = '0;
    w_valid_cnt = '0;
    for (int i = 0; i < NUM_BRANCHES; i++) begin
      w_valid_cnt = w_valid_cnt + 16'(IN_valid[i]);
      if (w_elig[i] && (!w_any || (w_age[i] < w_win_age))) begin
        w_any      = 1'b1;
        w_win      = CHAN_W'(i);
        w_win_age  = w_age[i];
        w_sel_sqN  = IN_sqN[i*SQN_W +: SQN_W];
        w_sel_pc   = IN_pc[i*PC_W +: PC_W];
        w_sel_meta = IN_meta[i*META_W +: META_W];
      end
    end
  end

  assign w_drops   = w_valid_cnt - 16'(w_any);
  assign w_cnt_sum = {1'b0, r_drop_cnt} + {1'b0, w_drops};

  always_comb begin
    w_state_nxt = r_state;
    if (w_any) begin
      w_state_nxt = S_FLUSH;
    end else if (IN_flushDone) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_sqN      <= '0;
      r_pc       <= '0;
      r_meta     <= '0;
      r_chan     <= '0;
      r_pend_sqN <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_valid    <= w_any;
      r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      if (w_any) begin
        r_sqN      <= w_sel_sqN;
        r_pc       <= w_sel_pc;
        r_meta     <= w_sel_meta;
        r_chan     <= w_win;
        r_pend_sqN <= w_sel_sqN;
      end
    end
  end

  assign OUT_valid    = r_valid;
  assign OUT_sqN      = r_sqN;
  assign OUT_pc       = r_pc;
  assign OUT_meta     = r_meta;
  assign OUT_chan     = r_chan;
  assign OUT_flushing = (r_state == S_FLUSH);
  assign OUT_dropCnt  = r_drop_cnt;

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// tb/tb_branch_redirect_arbiter.sv - vector-table bench for branch_redirect_arbiter
module tb_branch_redirect_arbiter;

  typedef struct {
    logic             rst;
    logic             fd;
    logic [6:0]       cur;
    logic [3:0]       v;
    logic [3:0][6:0]  sq;
    logic [3:0][31:0] pc;
    logic             eov;
    logic [6:0]       esq;
    logic [31:0]      epc;
    logic [1:0]       ech;
    logic             efl;
    logic [15:0]      edr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [27:0] in_sqn;
  logic [127:0] in_pc;
  logic [111:0] in_meta;
  logic [6:0]  in_cur;
  logic        in_fd;
  logic        out_valid;
  logic [6:0]  out_sqn;
  logic [31:0] out_pc;
  logic [27:0] out_meta;
  logic [1:0]  out_chan;
  logic        out_flushing;
  logic [15:0] out_drop;

  int n_cmp;
  int n_bad;
  vec_t vq[$];
  logic [27:0] exp_meta;

  branch_redirect_arbiter dut (
    .clk(clk), .rst(rst),
    .IN_valid(in_valid), .IN_sqN(in_sqn), .IN_pc(in_pc), .IN_meta(in_meta),
    .IN_ROB_curSqN(in_cur), .IN_flushDone(in_fd),
    .OUT_valid(out_valid), .OUT_sqN(out_sqn), .OUT_pc(out_pc), .OUT_meta(out_meta),
    .OUT_chan(out_chan), .OUT_flushing(out_flushing), .OUT_dropCnt(out_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic fd, input logic [6:0] cur, input logic [3:0] v,
                     input logic [3:0][6:0] sq, input logic [3:0][31:0] pc,
                     input logic eov, input logic [6:0] esq, input logic [31:0] epc,
                     input logic [1:0] ech, input logic efl, input logic [15:0] edr);
    vec_t t;
    t.rst = r; t.fd = fd; t.cur = cur; t.v = v; t.sq = sq; t.pc = pc;
    t.eov = eov; t.esq = esq; t.epc = epc; t.ech = ech; t.efl = efl; t.edr = edr;
    vq.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_meta = '0;
    in_meta = {28'h1230003, 28'h1230002, 28'h1230001, 28'h1230000};
    rst = 1'b1; in_valid = '0; in_sqn = '0; in_pc = '0; in_cur = '0; in_fd = 1'b0;

    //  rst fd  cur    v        sq (ch3..ch0)                   pc (ch3..ch0)                                 eov esq    epc          ech efl edr
    add(1, 0, 7'h00, 4'b0000, {7'h0, 7'h0, 7'h0, 7'h0},     {32'h0, 32'h0, 32'h0, 32'h0},                 0, 7'h00, 32'h0,     0, 0, 16'd0);
    add(0, 0, 7'h10, 4'b0100, {7'h0, 7'h14, 7'h0, 7'h0},    {32'h0, 32'h8000, 32'h0, 32'h0},              1, 7'h14, 32'h8000,  2, 1, 16'd0);
    add(0, 1, 7'h10, 4'b0000, {7'h0, 7'h0, 7'h0, 7'h0},     {32'h0, 32'h0, 32'h0, 32'h0},                 0, 7'h14, 32'h8000,  2, 0, 16'd0);
    add(0, 0, 7'h7C, 4'b1011, {7'h7E, 7'h0, 7'h7E, 7'h02},  {32'hA300, 32'h0, 32'hA100, 32'hA000},        1, 7'h7E, 32'hA100,  1, 1, 16'd2);
    add(0, 1, 7'h10, 4'b0001, {7'h0, 7'h0, 7'h0, 7'h20},    {32'h0, 32'h0, 32'h0, 32'hB000},              1, 7'h20, 32'hB000,  0, 1, 16'd2);
    add(0, 0, 7'h10, 4'b0001, {7'h0, 7'h0, 7'h0, 7'h25},    {32'h0, 32'h0, 32'h0, 32'hB500},              0, 7'h20, 32'hB000,  0, 1, 16'd3);
    add(0, 0, 7'h10, 4'b0010, {7'h0, 7'h0, 7'h20, 7'h0},    {32'h0, 32'h0, 32'hB600, 32'h0},              0, 7'h20, 32'hB000,  0, 1, 16'd4);
    add(0, 0, 7'h10, 4'b0100, {7'h0, 7'h1A, 7'h0, 7'h0},    {32'h0, 32'hC000, 32'h0, 32'h0},              1, 7'h1A, 32'hC000,  2, 1, 16'd4);
    add(0, 1, 7'h10, 4'b1000, {7'h30, 7'h0, 7'h0, 7'h0},    {32'hD000, 32'h0, 32'h0, 32'h0},              1, 7'h30, 32'hD000,  3, 1, 16'd4);
    add(0, 1, 7'h10, 4'b0000, {7'h0, 7'h0, 7'h0, 7'h0},     {32'h0, 32'h0, 32'h0, 32'h0},                 0, 7'h30, 32'hD000,  3, 0, 16'd4);
    add(0, 1, 7'h10, 4'b0000, {7'h0, 7'h0, 7'h0, 7'h0},     {32'h0, 32'h0, 32'h0, 32'h0},                 0, 7'h30, 32'hD000,  3, 0, 16'd4);
    add(0, 0, 7'h00, 4'b0110, {7'h0, 7'h05, 7'h05, 7'h0},   {32'h0, 32'hE200, 32'hE100, 32'h0},           1, 7'h05, 32'hE100,  1, 1, 16'd5);
    add(1, 0, 7'h00, 4'b0001, {7'h0, 7'h0, 7'h0, 7'h01},    {32'h0, 32'h0, 32'h0, 32'h1111},              0, 7'h00, 32'h0,     0, 0, 16'd0);
    add(0, 0, 7'h3F, 4'b0001, {7'h0, 7'h0, 7'h0, 7'h40},    {32'h0, 32'h0, 32'h0, 32'hF000},              1, 7'h40, 32'hF000,  0, 1, 16'd0);
    add(0, 0, 7'h3F, 4'b1111, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {32'hF400, 32'hF300, 32'hF200, 32'hF100},     1, 7'h3F, 32'hF100,  0, 1, 16'd3);

    foreach (vq[k]) begin
      rst      = vq[k].rst;
      in_fd    = vq[k].fd;
      in_cur   = vq[k].cur;
      in_valid = vq[k].v;
      in_sqn   = vq[k].sq;
      in_pc    = vq[k].pc;
      step();
      if (vq[k].rst) exp_meta = '0;
      else if (vq[k].eov) exp_meta = 28'h1230000 + 28'(vq[k].ech);
      check($sformatf("v%0d.valid", k), 32'(out_valid), 32'(vq[k].eov));
      check($sformatf("v%0d.sqN", k), 32'(out_sqn), 32'(vq[k].esq));
      check($sformatf("v%0d.pc", k), out_pc, vq[k].epc);
      check($sformatf("v%0d.meta", k), 32'(out_meta), 32'(exp_meta));
      check($sformatf("v%0d.chan", k), 32'(out_chan), 32'(vq[k].ech));
      check($sformatf("v%0d.flushing", k), 32'(out_flushing), 32'(vq[k].efl));
      check($sformatf("v%0d.dropCnt", k), 32'(out_drop), 32'(vq[k].edr));
    end

    // Saturation: all four channels every cycle with flushDone, so one wins and three drop.
    rst = 1'b1; in_valid = '0; in_fd = 1'b0;
    step();
    rst = 1'b0;
    in_cur = 7'h00;
    in_sqn = {7'h04, 7'h03, 7'h02, 7'h01};
    in_pc  = {32'h4, 32'h3, 32'h2, 32'h1};
    in_valid = 4'b1111;
    in_fd = 1'b1;
    for (int c = 0; c < 21844; c++) step();
    check("sat.pre", 32'(out_drop), 32'd65532);
    check("sat.pre_chan", 32'(out_chan), 32'd0);
    step();
    check("sat.exact", 32'(out_drop), 32'd65535);
    step();
    check("sat.plus3", 32'(out_drop), 32'hFFFF);
    in_fd = 1'b0;
    step();
    check("sat.plus4", 32'(out_drop), 32'hFFFF);
    check("sat.valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
